triangle_raster_scanner: RTL and testbench

Sequencer for the combinational TriangleRasterizer. On a start pulse it computes the screen-clamped integer bounding box of the triangle, then walks every pixel in raster order, one per cycle. It drives the rasterizer's sample coordinate, registers the returned colour, and emits pixels over a valid/ready stream to the framebuffer writer. It sits between the triangle setup stage and framebuffer write logic.

---
 rtl/triangle_raster_scanner_if.sv | 16 +
 rtl/triangle_raster_scanner.sv | 165 ++++++++++++++++
 tb/tb_triangle_raster_scanner.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/triangle_raster_scanner_if.sv
// Pixel stream from the raster scanner to the framebuffer writer.
// Valid/ready handshake carrying an integer coordinate and RGB888 colour.
interface triangle_raster_scanner_if #(
    parameter int COORD_W = 10
);
    logic               valid;
    logic               ready;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [7:0]         r;
    logic [7:0]         g;
    logic [7:0]         b;

    modport master (output valid, x, y, r, g, b, input ready);
    modport slave  (input valid, x, y, r, g, b, output ready);
endinterface

// File: rtl/triangle_raster_scanner.sv
// Walks the screen-clamped bounding box of a triangle in raster order,
// sampling a combinational rasterizer and streaming one pixel per cycle.
module triangle_raster_scanner #(
    parameter int SCREEN_W   = 320,
    parameter int SCREEN_H   = 240,
    parameter int COORD_W    = 10,
    parameter bit SKIP_BLACK = 1'b0
) (
    input  logic                      i_clk,
    input  logic                      i_reset_n,
    input  logic                      i_start,
    input  logic signed [31:0]        i_v1x,
    input  logic signed [31:0]        i_v1y,
    input  logic signed [31:0]        i_v2x,
    input  logic signed [31:0]        i_v2y,
    input  logic signed [31:0]        i_v3x,
    input  logic signed [31:0]        i_v3y,
    output logic signed [31:0]        o_raster_x,
    output logic signed [31:0]        o_raster_y,
    input  logic [7:0]                i_raster_r,
    input  logic [7:0]                i_raster_g,
    input  logic [7:0]                i_raster_b,
    triangle_raster_scanner_if.master pix,
    output logic                      o_busy,
    output logic                      o_done
);
    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_SCAN, S_DRAIN, S_DONE
    } state_t;

    localparam logic signed [31:0] XLIM = 32'(SCREEN_W - 1);
    localparam logic signed [31:0] YLIM = 32'(SCREEN_H - 1);

    function automatic logic signed [31:0] f_min3(
        input logic signed [31:0] a,
        input logic signed [31:0] b,
        input logic signed [31:0] c
    );
        logic signed [31:0] m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

    function automatic logic signed [31:0] f_max3(
        input logic signed [31:0] a,
        input logic signed [31:0] b,
        input logic signed [31:0] c
    );
        logic signed [31:0] m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    state_t             r_state;
    state_t             w_next;
    logic [COORD_W-1:0] r_cx;
    logic [COORD_W-1:0] r_cy;
    logic [COORD_W-1:0] r_xmin;
    logic [COORD_W-1:0] r_xmax;
    logic [COORD_W-1:0] r_ymax;
    logic               r_valid;
    logic [COORD_W-1:0] r_px;
    logic [COORD_W-1:0] r_py;
    logic [7:0]         r_r;
    logic [7:0]         r_g;
    logic [7:0]         r_b;

    logic signed [31:0] w_xmin_i, w_xmax_i, w_ymin_i, w_ymax_i;
    logic signed [31:0] w_xmin_c, w_xmax_c, w_ymin_c, w_ymax_c;
    logic               w_empty;
    logic               w_slot_free;
    logic               w_capture;
    logic               w_last;
    logic               w_black;

    // Floor is monotonic, so min/max on Q16.16 then shifting is exact.
    assign w_xmin_i = f_min3(i_v1x, i_v2x, i_v3x) >>> 16;
    assign w_xmax_i = f_max3(i_v1x, i_v2x, i_v3x) >>> 16;
    assign w_ymin_i = f_min3(i_v1y, i_v2y, i_v3y) >>> 16;
    assign w_ymax_i = f_max3(i_v1y, i_v2y, i_v3y) >>> 16;

    assign w_xmin_c = (w_xmin_i < 0) ? '0 : w_xmin_i;
    assign w_ymin_c = (w_ymin_i < 0) ? '0 : w_ymin_i;
    assign w_xmax_c = (w_xmax_i > XLIM) ? XLIM : w_xmax_i;
    assign w_ymax_c = (w_ymax_i > YLIM) ? YLIM : w_ymax_i;
    assign w_empty  = (w_xmin_c > w_xmax_c) || (w_ymin_c > w_ymax_c);

    assign w_slot_free = !r_valid || pix.ready;
    assign w_capture   = (r_state == S_SCAN) && w_slot_free;
    assign w_last      = (r_cx == r_xmax) && (r_cy == r_ymax);
    assign w_black     = (i_raster_r | i_raster_g | i_raster_b) == 8'h0;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (i_start) w_next = S_SETUP;
            S_SETUP: w_next = w_empty ? S_DONE : S_SCAN;
            S_SCAN:  if (w_capture && w_last) w_next = S_DRAIN;
            S_DRAIN: if (!r_valid) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_cx    <= '0;
            r_cy    <= '0;
            r_xmin  <= '0;
            r_xmax  <= '0;
            r_ymax  <= '0;
            r_valid <= 1'b0;
            r_px    <= '0;
            r_py    <= '0;
            r_r     <= '0;
            r_g     <= '0;
            r_b     <= '0;
        end else begin
            if (r_state == S_SETUP && !w_empty) begin
                r_cx   <= w_xmin_c[COORD_W-1:0];
                r_cy   <= w_ymin_c[COORD_W-1:0];
                r_xmin <= w_xmin_c[COORD_W-1:0];
                r_xmax <= w_xmax_c[COORD_W-1:0];
                r_ymax <= w_ymax_c[COORD_W-1:0];
            end
            if (w_capture) begin
                r_px    <= r_cx;
                r_py    <= r_cy;
                r_r     <= i_raster_r;
                r_g     <= i_raster_g;
                r_b     <= i_raster_b;
                r_valid <= !(SKIP_BLACK && w_black);
                if (r_cx == r_xmax) begin
                    r_cx <= r_xmin;
                    r_cy <= r_cy + 1'b1;
                end else begin
                    r_cx <= r_cx + 1'b1;
                end
            end else if (r_state == S_DRAIN && pix.ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_raster_x = {{(16-COORD_W){1'b0}}, r_cx, 16'h0};
    assign o_raster_y = {{(16-COORD_W){1'b0}}, r_cy, 16'h0};

    assign pix.valid = r_valid;
    assign pix.x     = r_px;
    assign pix.y     = r_py;
    assign pix.r     = r_r;
    assign pix.g     = r_g;
    assign pix.b     = r_b;

    assign o_busy = (r_state != S_IDLE);
    assign o_done = (r_state == S_DONE);
endmodule

// File: tb/tb_triangle_raster_scanner.sv
// Scoreboard bench for triangle_raster_scanner on an 8x8 screen,
// with one instance emitting black and one skipping it.
module tb_triangle_raster_scanner;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic signed [31:0] vx [3];
    logic signed [31:0] vy [3];
    int ax [3];
    int ay [3];

    logic start0 = 1'b0, start1 = 1'b0;
    logic ready0 = 1'b1, ready1 = 1'b1;
    logic signed [31:0] rx0, ry0, rx1, ry1;
    logic [7:0] rr0, gg0, bb0, rr1, gg1, bb1;
    logic busy0, done0, busy1, done1;

    triangle_raster_scanner_if #(.COORD_W(10)) p0 ();
    triangle_raster_scanner_if #(.COORD_W(10)) p1 ();
    assign p0.ready = ready0;
    assign p1.ready = ready1;

    function automatic logic [23:0] colf(input int x, input int y);
        if ((x & 1) != 0) return 24'h0;
        return {8'(x * 16 + y + 1), 8'(y * 3 + 7), 8'hA5};
    endfunction

    assign {rr0, gg0, bb0} = colf(int'(rx0 >>> 16), int'(ry0 >>> 16));
    assign {rr1, gg1, bb1} = colf(int'(rx1 >>> 16), int'(ry1 >>> 16));

    triangle_raster_scanner #(
        .SCREEN_W(8), .SCREEN_H(8), .COORD_W(10), .SKIP_BLACK(1'b0)
    ) dut0 (
        .i_clk(clk), .i_reset_n(rst_n), .i_start(start0),
        .i_v1x(vx[0]), .i_v1y(vy[0]), .i_v2x(vx[1]),
        .i_v2y(vy[1]), .i_v3x(vx[2]), .i_v3y(vy[2]),
        .o_raster_x(rx0), .o_raster_y(ry0),
        .i_raster_r(rr0), .i_raster_g(gg0), .i_raster_b(bb0),
        .pix(p0), .o_busy(busy0), .o_done(done0)
    );

    triangle_raster_scanner #(
        .SCREEN_W(8), .SCREEN_H(8), .COORD_W(10), .SKIP_BLACK(1'b1)
    ) dut1 (
        .i_clk(clk), .i_reset_n(rst_n), .i_start(start1),
        .i_v1x(vx[0]), .i_v1y(vy[0]), .i_v2x(vx[1]),
        .i_v2y(vy[1]), .i_v3x(vx[2]), .i_v3y(vy[2]),
        .o_raster_x(rx1), .o_raster_y(ry1),
        .i_raster_r(rr1), .i_raster_g(gg1), .i_raster_b(bb1),
        .pix(p1), .o_busy(busy1), .o_done(done1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [43:0] q0 [$];
    logic [43:0] q1 [$];
    wire  [43:0] cur0 = {p0.x, p0.y, p0.r, p0.g, p0.b};
    wire  [43:0] cur1 = {p1.x, p1.y, p1.r, p1.g, p1.b};
    logic [43:0] hold0, hold1, last0, last1;
    logic stall0 = 1'b0, stall1 = 1'b0;
    int hs0 = 0, hs1 = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            stall0 = 1'b0;
        end else begin
            if (stall0) chk("stable0", {p0.valid, cur0}, {1'b1, hold0});
            if (p0.valid && p0.ready) begin
                hs0++;
                last0 = cur0;
                if (q0.size() == 0) chk("extra0", 64'(cur0), '1);
                else chk("pix0", cur0, q0.pop_front());
            end
            if (done0) chk("drained0", q0.size(), 0);
            stall0 = p0.valid && !p0.ready;
            hold0  = cur0;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            stall1 = 1'b0;
        end else begin
            if (stall1) chk("stable1", {p1.valid, cur1}, {1'b1, hold1});
            if (p1.valid && p1.ready) begin
                hs1++;
                last1 = cur1;
                if (q1.size() == 0) chk("extra1", 64'(cur1), '1);
                else chk("pix1", cur1, q1.pop_front());
            end
            if (done1) chk("drained1", q1.size(), 0);
            stall1 = p1.valid && !p1.ready;
            hold1  = cur1;
        end
    end

    task automatic set_tri(input int x0, input int y0, input int x1,
                           input int y1, input int x2, input int y2,
                           input logic [15:0] frac);
        ax[0] = x0; ay[0] = y0;
        ax[1] = x1; ay[1] = y1;
        ax[2] = x2; ay[2] = y2;
        for (int i = 0; i < 3; i++) begin
            vx[i] = (32'(ax[i]) << 16) | {16'h0, frac};
            vy[i] = (32'(ay[i]) << 16) | {16'h0, frac};
        end
    endtask

    task automatic push_box(input int sel);
        int xmin, xmax, ymin, ymax;
        logic [23:0] c;
        xmin = ax[0]; xmax = ax[0];
        ymin = ay[0]; ymax = ay[0];
        for (int i = 1; i < 3; i++) begin
            if (ax[i] < xmin) xmin = ax[i];
            if (ax[i] > xmax) xmax = ax[i];
            if (ay[i] < ymin) ymin = ay[i];
            if (ay[i] > ymax) ymax = ay[i];
        end
        if (xmin < 0) xmin = 0;
        if (ymin < 0) ymin = 0;
        if (xmax > 7) xmax = 7;
        if (ymax > 7) ymax = 7;
        if (xmin > xmax || ymin > ymax) return;
        for (int y = ymin; y <= ymax; y++)
            for (int x = xmin; x <= xmax; x++) begin
                c = colf(x, y);
                if (sel == 1 && c == 24'h0) continue;
                if (sel == 1) q1.push_back({10'(x), 10'(y), c});
                else q0.push_back({10'(x), 10'(y), c});
            end
    endtask

    int first_v, last_v, nv, done_c, ndone;
    bit busyv [200];
    bit validv [200];

    task automatic run(input int sel, input int ncyc, input int rmode,
                       input int sp2, input int rc);
        logic st, rd, vl, bz, dn;
        first_v = -1; last_v = -1; nv = 0; done_c = -1; ndone = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk);
            #1;
            rst_n = (c != rc);
            st = (c == 0) || (c == sp2);
            rd = (rmode == 0) ? 1'b1 : ((c % 2) == 0);
            if (sel == 0) begin start0 = st; ready0 = rd; end
            else begin start1 = st; ready1 = rd; end
            @(negedge clk);
            vl = sel ? p1.valid : p0.valid;
            bz = sel ? busy1 : busy0;
            dn = sel ? done1 : done0;
            busyv[c]  = bz;
            validv[c] = vl;
            if (vl) begin
                if (first_v < 0) first_v = c;
                last_v = c;
                nv++;
            end
            if (dn) begin
                done_c = c;
                ndone++;
            end
        end
        @(posedge clk);
        #1;
        start0 = 1'b0; start1 = 1'b0;
        ready0 = 1'b1; ready1 = 1'b1;
        rst_n  = 1'b1;
    endtask

    int h;
    int nb;

    initial begin
        set_tri(0, 0, 3, 0, 0, 3, 16'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", p0.valid, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_pix", cur0, 0);
        chk("rst_rxy", {rx0, ry0}, 0);
        chk("rst_valid1", {p1.valid, busy1, done1}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // basic 4x4 box, ready high
        push_box(0);
        run(0, 24, 0, -1, -1);
        chk("t1_first", first_v, 3);
        chk("t1_last", last_v, 18);
        chk("t1_count", nv, 16);
        chk("t1_done_c", done_c, 20);
        chk("t1_ndone", ndone, 1);
        chk("t1_busy", {busyv[0], busyv[1], busyv[20], busyv[21]}, 4'b0110);

        // ready toggling
        push_box(0);
        h = hs0;
        run(0, 60, 1, -1, -1);
        chk("t2_hs", hs0 - h, 16);
        chk("t2_ndone", ndone, 1);
        chk("t2_qempty", q0.size(), 0);

        // clamped box with fractional vertices
        set_tri(-5, -5, 10, 2, 2, 10, 16'h8000);
        push_box(0);
        h = hs0;
        run(0, 90, 0, -1, -1);
        chk("t3_hs", hs0 - h, 64);
        chk("t3_lastpix", last0, {10'd7, 10'd7, colf(7, 7)});
        chk("t3_done_c", done_c, 68);
        chk("t3_ndone", ndone, 1);

        // fully off-screen triangle
        set_tri(-9, 0, -4, 3, -2, 1, 16'h0);
        push_box(0);
        run(0, 8, 0, -1, -1);
        chk("t4_count", nv, 0);
        chk("t4_done_c", done_c, 2);
        chk("t4_busy", {busyv[0], busyv[1], busyv[2], busyv[3]}, 4'b0110);

        // skip-black instance
        set_tri(0, 0, 3, 0, 0, 3, 16'h0);
        push_box(1);
        h = hs1;
        run(1, 30, 0, -1, -1);
        chk("t5_hs", hs1 - h, 8);
        chk("t5_first", first_v, 3);
        chk("t5_done_c", done_c, 19);
        chk("t5_ndone", ndone, 1);

        // start pulse while busy, then reset mid-scan
        push_box(0);
        run(0, 16, 0, 5, 10);
        q0.delete();
        chk("t6_valid", validv[11], 0);
        chk("t6_busy", busyv[11], 0);
        chk("t6_ndone", ndone, 0);
        nb = 0;
        for (int c = 11; c < 16; c++) nb += int'(busyv[c]);
        chk("t6_norestart", nb, 0);
        chk("t6_pix", cur0, 0);
        chk("t6_rxy", {rx0, ry0}, 0);

        push_box(0);
        h = hs0;
        run(0, 26, 0, -1, -1);
        chk("t6_hs", hs0 - h, 16);
        chk("t6_first", first_v, 3);
        chk("t6_done_c", done_c, 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
